bopit_round_ctrl: RTL

Round sequencer for the Bop-It game. Consumes the single-cycle tick strobe derived from the clock divider's 1 Hz output, issues a pseudo-random command each round, times the player's response in ticks, and keeps score. The response window shrinks as the score grows. It sits between the clock divider and debounced button inputs on one side, and the display/audio logic on the other.

---
 rtl/bopit_pkg.sv | 38 +++
 rtl/bopit_lfsr.sv | 29 ++
 rtl/bopit_round_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bopit_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bopit_pkg: command, state and action encodings shared by the Bop-It
// controller, display and audio blocks.            Rev 1.0
// ------------------------------------------------------------------
package bopit_pkg;

  localparam int CMD_W   = 2;
  localparam int ACT_W   = 3;
  localparam int STATE_W = 3;

  localparam logic [CMD_W-1:0] CMD_NONE  = 2'd0;
  localparam logic [CMD_W-1:0] CMD_BOP   = 2'd1;
  localparam logic [CMD_W-1:0] CMD_TWIST = 2'd2;
  localparam logic [CMD_W-1:0] CMD_PULL  = 2'd3;

  localparam int ACT_BOP   = 0;
  localparam int ACT_TWIST = 1;
  localparam int ACT_PULL  = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARM  = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_HIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER = 3'd4;

  // Action pattern that counts as a correct response to a command.
  function automatic logic [ACT_W-1:0] cmd_to_act(input logic [CMD_W-1:0] c);
    logic [ACT_W-1:0] v;
    v            = '0;
    v[ACT_BOP]   = (c == CMD_BOP);
    v[ACT_TWIST] = (c == CMD_TWIST);
    v[ACT_PULL]  = (c == CMD_PULL);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bopit_lfsr.sv
`default_nettype none
// ------------------------------------------------------------------
// bopit_lfsr: free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1.
// Rev 1.0
// ------------------------------------------------------------------
module bopit_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       masterclk,
  input  logic       rst,
  output logic [7:0] value
);

  localparam logic [7:0] c_tap_mask = 8'hB8;

  logic [7:0] r_lfsr;

  always_ff @(posedge masterclk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_tap_mask : 8'h00);
    end
  end

  assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/bopit_round_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// bopit_round_ctrl: issues random commands, times responses in ticks,
// keeps score and shrinks the window as the score grows.   Rev 1.0
// ------------------------------------------------------------------
module bopit_round_ctrl
  import bopit_pkg::*;
#(
  parameter int         INIT_LIMIT    = 8,
  parameter int         MIN_LIMIT     = 2,
  parameter int         SPEEDUP_EVERY = 4,
  parameter int         MAX_SCORE     = 99,
  parameter int         SCORE_W       = 7,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic               masterclk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [ACT_W-1:0]   act,
  output logic [CMD_W-1:0]   cmd,
  output logic               cmd_valid,
  output logic [3:0]         time_left,
  output logic [SCORE_W-1:0] score,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over,
  output logic               game_won
);

  localparam int SUCC_W = $clog2(SPEEDUP_EVERY + 1);

  localparam logic [3:0]         c_init_limit = 4'(INIT_LIMIT);
  localparam logic [3:0]         c_min_limit  = 4'(MIN_LIMIT);
  localparam logic [SCORE_W-1:0] c_max_score  = SCORE_W'(MAX_SCORE);
  localparam logic [SUCC_W-1:0]  c_succ_last  = SUCC_W'(SPEEDUP_EVERY - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [CMD_W-1:0]   r_cmd;
  logic [3:0]         r_time_left;
  logic [3:0]         r_limit;
  logic [SCORE_W-1:0] r_score;
  logic [SUCC_W-1:0]  r_succ;
  logic               r_miss;

  logic [7:0]         w_lfsr;
  logic [CMD_W-1:0]   w_rand_cmd;
  logic               w_act_any;
  logic               w_act_ok;
  logic               w_expire;

  bopit_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .masterclk (masterclk),
    .rst       (rst),
    .value     (w_lfsr)
  );

  assign w_rand_cmd = CMD_W'(w_lfsr % 8'd3) + 2'd1;
  assign w_act_any  = |act;
  assign w_act_ok   = (act == cmd_to_act(r_cmd));
  assign w_expire   = tick && (r_time_left == 4'd1);

  always_ff @(posedge masterclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A response arriving with the expiring tick is judged first: act wins.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (start) w_next_state = ST_ARM;
      ST_ARM:           w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (w_act_any) begin
          w_next_state = w_act_ok ? ST_HIT : ST_OVER;
        end else if (w_expire) begin
          w_next_state = ST_OVER;
        end
      end
      ST_HIT:  w_next_state = (r_score == c_max_score) ? ST_OVER : ST_ARM;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge masterclk or negedge rst) begin
    if (!rst) begin
      r_cmd       <= CMD_NONE;
      r_time_left <= '0;
      r_limit     <= c_init_limit;
      r_score     <= '0;
      r_succ      <= '0;
      r_miss      <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_score <= '0;
            r_succ  <= '0;
            r_limit <= c_init_limit;
          end
        end
        ST_ARM: begin
          r_cmd       <= w_rand_cmd;
          r_time_left <= r_limit;
        end
        ST_WAIT: begin
          if (w_act_any) begin
            if (w_act_ok) begin
              if (r_score != c_max_score) r_score <= r_score + SCORE_W'(1);
            end else begin
              r_miss <= 1'b1;
            end
          end else if (tick) begin
            r_time_left <= r_time_left - 4'd1;
            if (w_expire) r_miss <= 1'b1;
          end
        end
        ST_HIT: begin
          if (r_succ == c_succ_last) begin
            r_succ <= '0;
            if (r_limit > c_min_limit) r_limit <= r_limit - 4'd1;
          end else begin
            r_succ <= r_succ + SUCC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd       = CMD_NONE;
    cmd_valid = 1'b0;
    hit_pulse = 1'b0;
    game_over = 1'b0;
    game_won  = 1'b0;
    case (r_state)
      ST_WAIT: begin
        cmd       = r_cmd;
        cmd_valid = 1'b1;
      end
      ST_HIT:  hit_pulse = 1'b1;
      ST_OVER: begin
        game_over = 1'b1;
        game_won  = (r_score == c_max_score);
      end
      default: ;
    endcase
  end

  assign time_left  = r_time_left;
  assign score      = r_score;
  assign miss_pulse = r_miss;

endmodule
`default_nettype wire
